// File: rtl/output_channel_scanner.sv
// output_channel_scanner: walks the set bits of a channel mask, steering the wavelet output mux
// and presenting each settled channel sample on a valid/ready port.
module output_channel_scanner #(
   parameter int NUM_FILTERS    = 8,
   parameter int SUM_TRUNCATION = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_start,
   input  logic                      i_continuous,
   input  logic [NUM_FILTERS-1:0]    i_channel_mask,
   output logic [7:0]                o_select_output_channel,
   input  logic [SUM_TRUNCATION-1:0] i_multiplexed_wavelet_out,
   output logic [SUM_TRUNCATION-1:0] o_sample_data,
   output logic [2:0]                o_sample_channel,
   output logic                      o_sample_valid,
   input  logic                      i_sample_ready,
   output logic                      o_frame_start,
   output logic                      o_frame_end,
   output logic                      o_busy
);
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, PRESENT} state_t;
   state_t                 state_q;
   logic [NUM_FILTERS-1:0] mask_q;
   logic [2:0]             sel_q;
   logic                   first_q;
   logic [3:0]             lo, hi;
   // {found, index} of the lowest set bit of m at or above position from
   function automatic logic [3:0] find_from(input logic [NUM_FILTERS-1:0] m, input int from);
      logic [3:0] r;
      r = '0;
      for (int i = NUM_FILTERS - 1; i >= 0; i--)
         if (m[i] && i >= from) r = {1'b1, 3'(i)};
      return r;
   endfunction
   assign lo = find_from(i_channel_mask, 0);
   assign hi = find_from(mask_q, int'(sel_q) + 1);
   assign o_select_output_channel = {5'b0, sel_q};
   assign o_busy = state_q != IDLE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         mask_q           <= '0;
         sel_q            <= '0;
         first_q          <= 1'b0;
         o_sample_data    <= '0;
         o_sample_channel <= '0;
         o_sample_valid   <= 1'b0;
         o_frame_start    <= 1'b0;
         o_frame_end      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (i_start && lo[3]) begin
               mask_q  <= i_channel_mask;
               sel_q   <= lo[2:0];
               first_q <= 1'b1;
               state_q <= SETTLE;
            end
            SETTLE: state_q <= CAPTURE;
            CAPTURE: begin
               o_sample_data    <= i_multiplexed_wavelet_out;
               o_sample_channel <= sel_q;
               o_sample_valid   <= 1'b1;
               o_frame_start    <= first_q;
               o_frame_end      <= !hi[3];
               state_q          <= PRESENT;
            end
            PRESENT: if (i_sample_ready) begin
               o_sample_valid <= 1'b0;
               o_frame_start  <= 1'b0;
               o_frame_end    <= 1'b0;
               first_q        <= 1'b0;
               if (hi[3]) begin
                  sel_q   <= hi[2:0];
                  state_q <= SETTLE;
               end else if (i_continuous && lo[3]) begin
                  mask_q  <= i_channel_mask;
                  sel_q   <= lo[2:0];
                  first_q <= 1'b1;
                  state_q <= SETTLE;
               end else state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_output_channel_scanner.sv
// tb_output_channel_scanner: scoreboard of expected frame samples plus directed scenarios.
module tb_output_channel_scanner;
   typedef struct packed {logic [7:0] d; logic [2:0] ch; logic fs; logic fe;} item_t;
   logic       clk = 0, rst = 0, i_start = 0, i_continuous = 0, i_sample_ready = 0;
   logic [7:0] i_channel_mask = 0, sel, mux_q = 0, o_sample_data;
   logic [2:0] o_sample_channel;
   logic       o_sample_valid, o_frame_start, o_frame_end, o_busy;
   int         checks = 0, errors = 0, cyc = 0;
   item_t      exp_q[$], log_q[$];
   int         log_cyc[$];
   logic       model_busy = 0, exp_valid = 0, busy_seen = 0;
   int         wait_cnt = 0;

   output_channel_scanner dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_continuous(i_continuous),
      .i_channel_mask(i_channel_mask), .o_select_output_channel(sel),
      .i_multiplexed_wavelet_out(mux_q), .o_sample_data(o_sample_data),
      .o_sample_channel(o_sample_channel), .o_sample_valid(o_sample_valid),
      .i_sample_ready(i_sample_ready), .o_frame_start(o_frame_start),
      .o_frame_end(o_frame_end), .o_busy(o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      mux_q <= 8'h10 + sel;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_frame(input logic [7:0] m);
      int first, last;
      first = -1;
      for (int i = 0; i < 8; i++) if (m[i]) begin
         if (first < 0) first = i;
         last = i;
      end
      for (int i = 0; i < 8; i++)
         if (m[i]) exp_q.push_back('{8'h10 + 8'(i), 3'(i), i == first, i == last});
   endtask

   // Compare at negedge, then advance the model to what the next rising edge must produce.
   always @(negedge clk) begin
      item_t it;
      if (!rst) begin
         exp_q.delete();
         model_busy = 0;
         exp_valid = 0;
         wait_cnt = 0;
      end
      if (o_busy) busy_seen = 1;
      check("busy", o_busy, model_busy);
      check("valid", o_sample_valid, exp_valid);
      check("select_hi_zero", sel[7:3], 0);
      if (o_sample_valid && exp_valid) begin
         if (exp_q.size() == 0) check("unexpected_sample", 1, 0);
         else begin
            check("sample_data", o_sample_data, exp_q[0].d);
            check("sample_channel", o_sample_channel, exp_q[0].ch);
            check("frame_start", o_frame_start, exp_q[0].fs);
            check("frame_end", o_frame_end, exp_q[0].fe);
         end
      end
      if (!rst) ;
      else if (wait_cnt > 0) begin
         wait_cnt--;
         if (wait_cnt == 0) exp_valid = 1;
      end else if (exp_valid && i_sample_ready && exp_q.size() > 0) begin
         it = exp_q.pop_front();
         log_q.push_back({o_sample_data, o_sample_channel, o_frame_start, o_frame_end});
         log_cyc.push_back(cyc);
         exp_valid = 0;
         if (exp_q.size() > 0) wait_cnt = 2;
         else if (i_continuous && i_channel_mask != 0) begin
            push_frame(i_channel_mask);
            wait_cnt = 2;
         end else model_busy = 0;
      end else if (!model_busy && i_start && i_channel_mask != 0) begin
         push_frame(i_channel_mask);
         model_busy = 1;
         wait_cnt = 2;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      i_start = 1;
      tick(1);
      i_start = 0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      do begin tick(1); n++; end while (o_busy && n < lim);
      check("idle_timeout", o_busy, 0);
   endtask

   task automatic wait_chan(input logic [2:0] ch);
      int n = 0;
      do begin tick(1); n++; end while (!(o_sample_valid && o_sample_channel == ch) && n < 100);
      check("wait_chan_timeout", o_sample_valid && o_sample_channel == ch, 1);
   endtask

   initial begin
      #12;
      check("rst_select", sel, 0);
      check("rst_data", o_sample_data, 0);
      check("rst_valid", o_sample_valid, 0);
      check("rst_busy", o_busy, 0);
      tick(2);
      rst = 1;
      tick(2);
      // full mask, ready always high, a second start mid-frame must be ignored
      i_channel_mask = 8'hFF; i_sample_ready = 1;
      log_q.delete(); log_cyc.delete();
      pulse_start();
      tick(5);
      pulse_start();
      wait_idle(60);
      tick(3);
      check("a_count", log_q.size(), 8);
      if (log_q.size() == 8) begin
         check("a_first_data", log_q[0].d, 8'h10);
         check("a_last_data", log_q[7].d, 8'h17);
         check("a_last_ch", log_q[7].ch, 7);
         check("a_first_fs", {log_q[0].fs, log_q[0].fe}, 2'b10);
         check("a_last_fe", {log_q[7].fs, log_q[7].fe}, 2'b01);
         for (int i = 1; i < 8; i++) check("a_gap", log_cyc[i] - log_cyc[i-1], 3);
      end
      // sparse mask
      i_channel_mask = 8'b1010_0100;
      log_q.delete(); log_cyc.delete();
      pulse_start();
      i_channel_mask = 8'h01;
      wait_idle(60);
      check("b_count", log_q.size(), 3);
      if (log_q.size() == 3) begin
         check("b_ch0", log_q[0].ch, 2);
         check("b_ch1", log_q[1].ch, 5);
         check("b_ch2", log_q[2].ch, 7);
         check("b_flags0", {log_q[0].fs, log_q[0].fe}, 2'b10);
         check("b_flags2", {log_q[2].fs, log_q[2].fe}, 2'b01);
      end
      // backpressure on ch3
      i_channel_mask = 8'hFF;
      log_q.delete(); log_cyc.delete();
      pulse_start();
      wait_chan(3);
      i_sample_ready = 0;
      tick(5);
      i_sample_ready = 1;
      wait_idle(80);
      check("c_count", log_q.size(), 8);
      if (log_q.size() == 8) begin
         check("c_ch3", log_q[3].ch, 3);
         check("c_ch3_data", log_q[3].d, 8'h13);
         check("c_gap", log_cyc[3] - log_cyc[2], 8);
      end
      // continuous single-channel frames
      i_channel_mask = 8'h01; i_continuous = 1;
      log_q.delete(); log_cyc.delete();
      pulse_start();
      for (int n = 0; n < 60 && log_q.size() < 4; n++) tick(1);
      i_channel_mask = 8'h00;
      wait_idle(20);
      i_continuous = 0;
      check("d_enough", log_q.size() >= 4, 1);
      for (int i = 0; i < log_q.size(); i++) begin
         check("d_item", log_q[i], {8'h10, 3'd0, 2'b11});
         if (i > 0) check("d_gap", log_cyc[i] - log_cyc[i-1], 3);
      end
      // asynchronous reset while presenting ch4
      i_channel_mask = 8'hFF;
      log_q.delete(); log_cyc.delete();
      pulse_start();
      wait_chan(4);
      i_sample_ready = 0;
      #2 rst = 0;
      #1;
      check("e_select", sel, 0);
      check("e_outputs", {o_sample_data, o_sample_channel, o_sample_valid, o_frame_start, o_frame_end, o_busy}, 0);
      tick(2);
      rst = 1;
      i_sample_ready = 1;
      busy_seen = 0;
      tick(20);
      check("e_quiet_busy", busy_seen, 0);
      check("e_transfers", log_q.size(), 4);
      // empty mask ignores start
      i_channel_mask = 8'h00;
      busy_seen = 0;
      log_q.delete();
      pulse_start();
      tick(10);
      check("f_busy_seen", busy_seen, 0);
      check("f_transfers", log_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
